sram_controller: RTL and testbench

- Memory-side responder to the MEM stage's load/store requests.
- Converts one 32-bit word access into two 16-bit external SRAM accesses, with a programmable number of wait cycles per access.
- Holds `ready` low while an access is in progress, which the pipeline uses as a freeze source.
- Sits between MEM stage and the external asynchronous SRAM.

---
 rtl/sram_controller.sv | 137 +++++++++++++
 tb/tb_sram_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses of WAIT_CYCLES each; ready is low for 2*WAIT_CYCLES+1 cycles.
// SRAM_CTRL_READ_BUFFER_EN adds a one-entry write-through read buffer that lets a repeated read skip the SRAM.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);
  localparam int unsigned WIDX_W = SRAM_ADDR_W - 1;

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        wcnt;
  logic              op_wr;
  logic [WIDX_W-1:0] widx;
  logic [WIDX_W-1:0] req_widx;
  logic [31:0]       wdata;
  logic              req;
  logic              last_wait;
  logic              buf_hit;

  assign req       = wr_en | rd_en;
  // Truncation makes out-of-range addresses wrap silently.
  assign req_widx  = WIDX_W'((address - BASE_ADDR) >> 2);
  assign last_wait = (wcnt == 4'(WAIT_CYCLES - 1));

`ifdef SRAM_CTRL_READ_BUFFER_EN
  logic              buf_vld;
  logic [WIDX_W-1:0] buf_tag;
  logic [31:0]       buf_dat;

  assign buf_hit = rd_en & ~wr_en & buf_vld & (buf_tag == req_widx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld <= 1'b0;
      buf_tag <= '0;
      buf_dat <= '0;
    end else if (state == ACC_HI && last_wait) begin
      buf_vld <= 1'b1;
      buf_tag <= widx;
      buf_dat <= op_wr ? wdata : {sram_dq_in, read_data[15:0]};
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nxt = buf_hit ? DONE : ACC_LO;
      end
      ACC_LO: begin
        sram_addr = {widx, 1'b0};
        if (op_wr) begin
          sram_dq_out = wdata[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (last_wait) state_nxt = ACC_HI;
      end
      ACC_HI: begin
        sram_addr = {widx, 1'b1};
        if (op_wr) begin
          sram_dq_out = wdata[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (last_wait) state_nxt = DONE;
      end
      default: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt      <= '0;
      op_wr     <= 1'b0;
      widx      <= '0;
      wdata     <= '0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (req) begin
            op_wr <= wr_en;
            widx  <= req_widx;
            wdata <= write_data;
`ifdef SRAM_CTRL_READ_BUFFER_EN
            if (buf_hit) read_data <= buf_dat;
`endif
          end
        end
        ACC_LO: begin
          wcnt <= last_wait ? 4'd0 : wcnt + 4'd1;
          if (last_wait && !op_wr) read_data[15:0] <= sram_dq_in;
        end
        ACC_HI: begin
          wcnt <= last_wait ? 4'd0 : wcnt + 4'd1;
          if (last_wait && !op_wr) read_data[31:16] <= sram_dq_in;
        end
        default: wcnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: reset values, directed vectors, corner sequences and random traffic against a word-level model.
module tb_sram_controller;
  localparam int W    = 2;
  localparam int FULL = 2 * W + 1;
`ifdef SRAM_CTRL_READ_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  localparam int HIT = BUF ? 1 : FULL;

  logic        clk, rst, wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  sram_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write on strobe.
  logic [15:0] mem [0:(1<<18)-1];
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Per-access observations
  int          low, we_lo, oe_cnt;
  logic [31:0] rd_done;
  logic        done_we;
  logic [17:0] addr_log [$];
  logic        we_log [$];
  logic [15:0] dq_log [$];

  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
    bit got;
    got = 0;
    addr_log.delete(); we_log.delete(); dq_log.delete();
    low = 0; we_lo = 0; oe_cnt = 0; rd_done = '0; done_we = 1'b0;
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; write_data = d;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= hold) begin wr_en = 1'b0; rd_en = 1'b0; end
      #1;
      if (!sram_we_n) we_lo++;
      if (sram_dq_oe) oe_cnt++;
      if (ready) begin
        rd_done = read_data; done_we = sram_we_n; got = 1;
        break;
      end
      addr_log.push_back(sram_addr);
      we_log.push_back(sram_we_n);
      dq_log.push_back(sram_dq_out);
      low++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL access_timeout: ready never rose, required within 64 cycles");
    end
  endtask

  task automatic check_bus(input string nm, input logic w, input int widx, input logic [31:0] d);
    if (low == FULL && addr_log.size() == FULL) begin
      for (int c = 1; c <= 2 * W; c++) begin
        chk($sformatf("%s_addr%0d", nm, c), 32'(addr_log[c]), 32'(2 * widx + ((c > W) ? 1 : 0)));
        chk($sformatf("%s_we%0d", nm, c), 32'(we_log[c]), 32'(!w));
        if (w) chk($sformatf("%s_dq%0d", nm, c), 32'(dq_log[c]), 32'((c <= W) ? d[15:0] : d[31:16]));
      end
    end
    chk({nm, "_we_cycles"}, 32'(we_lo), 32'(w ? 2 * W : 0));
    chk({nm, "_oe_cycles"}, 32'(oe_cnt), 32'(w ? 2 * W : 0));
    chk({nm, "_done_we"}, 32'(done_we), 32'd1);
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    int          low;
    logic [31:0] rd;
  } vec_t;

  vec_t tab [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] mword [8];
    logic [31:0] model_rd, a, d;
    logic        bv, w;
    int          btag, k, kind, alias_sel, exp_low;

    tab[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, FULL, 32'h0};
    tab[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,        HIT,  32'hDEADBEEF};
    tab[2] = '{1'b1, 1'b0, 32'd1028, 32'h12345678, FULL, 32'hDEADBEEF};
    tab[3] = '{1'b0, 1'b1, 32'd1028, 32'h0,        HIT,  32'h12345678};
    tab[4] = '{1'b0, 1'b1, 32'd1024, 32'h0,        FULL, 32'hDEADBEEF};
    tab[5] = '{1'b0, 1'b1, 32'd1024, 32'h0,        HIT,  32'hDEADBEEF};
    tab[6] = '{1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, FULL, 32'hDEADBEEF};
    tab[7] = '{1'b0, 1'b1, 32'd1032, 32'h0,        HIT,  32'hA5A5A5A5};

    clk = 0; rst = 1; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("idle_ready", 32'(ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      access(tab[i].w, tab[i].r, tab[i].a, tab[i].d, 1000);
      chk($sformatf("vec%0d_low", i), 32'(low), 32'(tab[i].low));
      chk($sformatf("vec%0d_rdata", i), rd_done, tab[i].rd);
      check_bus($sformatf("vec%0d", i), tab[i].w, int'((tab[i].a - 32'd1024) >> 2), tab[i].d);
    end

    // Write zero then read it back (buffer hit when the buffer is built in)
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1000);
    chk("wz_low", 32'(low), 32'(FULL));
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1000);
    chk("rz_low", 32'(low), 32'(HIT));
    chk("rz_rdata", rd_done, 32'h0);
    check_bus("rz", 1'b0, 0, 32'h0);

    // Request dropped after the first cycle still completes
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1);
    chk("drop_low", 32'(low), 32'(FULL));
    chk("drop_rdata", rd_done, 32'h12345678);
    check_bus("drop", 1'b0, 1, 32'h0);

    // Reset in the middle of the high half of a write
    @(negedge clk);
    wr_en = 1; address = 32'd1032; write_data = 32'h11112222;
    repeat (W + 1) @(negedge clk);
    #1;
    chk("midw_we_n", 32'(sram_we_n), 32'd0);
    chk("midw_addr", 32'(sram_addr), 32'd5);
    wr_en = 0; rst = 1;
    #1;
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
    chk("midrst_read_data", read_data, 32'h0);
    chk("midrst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    #1;
    chk("postrst_ready", 32'(ready), 32'd1);
    chk("postrst_addr", 32'(sram_addr), 32'd0);
    rst = 0;

    // Random traffic over an 8-word window, including aliased addresses
    model_rd = 32'h0; bv = 1'b0; btag = -1;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      access(1'b1, 1'b0, 32'd1024 + 32'(4 * i), d, 1000);
      chk($sformatf("init%0d_low", i), 32'(low), 32'(FULL));
      mword[i] = d; bv = 1'b1; btag = i;
    end
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      k = $urandom_range(0, 7);
      alias_sel = $urandom_range(0, 2);
      d = $urandom;
      a = 32'd1024 + 32'(4 * k);
      if (alias_sel == 1) a = a + 32'h0008_0000;
      if (alias_sel == 2) a = a - 32'h0008_0000;
      w = (kind <= 1);
      access(w, kind != 0, a, d, 1000);
      if (w) begin
        exp_low = FULL;
        mword[k] = d;
      end else begin
        exp_low = (BUF && bv && btag == k) ? 1 : FULL;
        model_rd = mword[k];
      end
      bv = 1'b1; btag = k;
      chk($sformatf("rnd%0d_low", i), 32'(low), 32'(exp_low));
      chk($sformatf("rnd%0d_rdata", i), rd_done, model_rd);
      chk($sformatf("rnd%0d_we_cycles", i), 32'(we_lo), 32'(w ? 2 * W : 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
